// File: rtl/arith_pkg.sv
// Shared definitions for the digit-serial add/subtract engine.
//   state_t     : controller states (IDLE, RUN)
//   MODE_ADD/SUB: values of the mode input m
//   params_ok() : checks that WIDTH/DIGIT describe a buildable unit
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // WIDTH must be at least 2 and an exact multiple of DIGIT.
    function automatic bit params_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/addsub_digit_slice.sv
// Combinational DIGIT-bit ripple adder used once per cycle by the serial unit.
// Ports:
//   x, y     : DIGIT-bit addends
//   cin      : carry into bit 0
//   sum      : DIGIT-bit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (feeds the signed-overflow flag)
module addsub_digit_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        sum      = '0;
        c_msb_in = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb_in = c;
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial WIDTH-bit adder/subtractor. Processes DIGIT bits per clock,
// LSB first, carrying between cycles in a register. A result appears after
// WIDTH/DIGIT cycles with registered flags.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while busy=0
//   a, b, m    : operands and mode (0 = a+b, 1 = a-b), sampled at accept
//   busy       : operation in progress
//   done       : one-cycle pulse when s and flags have been updated
//   s          : result (mod 2^WIDTH)
//   c_out      : carry out of MSB (subtract: 1 = no borrow)
//   v, z, n    : signed overflow, zero, negative
module serial_addsub_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
            $error("serial_addsub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dc_msb;
    logic [WIDTH-1:0] next_acc;
    logic             last_step;

    addsub_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (op_a[DIGIT-1:0]),
        .y        (op_b[DIGIT-1:0]),
        .cin      (carry),
        .sum      (dsum),
        .cout     (dcout),
        .c_msb_in (dc_msb)
    );

    // New digit enters at the MSB end; after NSTEP shifts the first digit
    // has reached bit 0 and the register holds the full result.
    assign next_acc  = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    assign last_step = (cnt == CNT_W'(NSTEP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert b here, inject the +1 as carry-in.
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{m == MODE_SUB}};
                        carry <= (m == MODE_SUB);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    acc   <= next_acc;
                    carry <= dcout;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        // Final digit holds the MSB, so its carries give c_out and v.
                        s     <= next_acc;
                        c_out <= dcout;
                        v     <= dc_msb ^ dcout;
                        z     <= (next_acc == '0);
                        n     <= next_acc[WIDTH-1];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
